// File: rtl/mac_operand_sequencer_pkg.sv
// mac_operand_sequencer_pkg: shared mode encodings, lane constants and beat-count helpers
package mac_operand_sequencer_pkg;
  localparam int MAC_MIN_WIDTH_DEF = 8;
  localparam int MAC_LANES = 4;
  typedef enum logic [1:0] {
    MODE_SINGLE = 2'b00,
    MODE_DUAL   = 2'b01,
    MODE_QUAD   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;
  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;
  function automatic mode_e seq_mode(input logic [1:0] m);
    return m == MODE_RSVD ? MODE_SINGLE : mode_e'(m);
  endfunction
  function automatic logic [1:0] last_beat(input mode_e m);
    return m == MODE_QUAD ? 2'd3 : m == MODE_DUAL ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/mac_operand_sequencer_if.sv
// mac_operand_sequencer_if: operand input handshake and per-lane output bus
interface mac_operand_sequencer_if #(
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int MAC_CONF_WIDTH = 3,
  parameter int MAC_OPD_WIDTH  = 4 * MAC_MIN_WIDTH
);
  logic [MAC_CONF_WIDTH-1:0] cfg;
  logic [MAC_OPD_WIDTH-1:0]  opd_a;
  logic [MAC_OPD_WIDTH-1:0]  opd_b;
  logic                      in_valid;
  logic                      in_ready;
  logic [MAC_MIN_WIDTH-1:0]  out_a0, out_a1, out_a2, out_a3;
  logic [MAC_MIN_WIDTH-1:0]  out_b0, out_b1, out_b2, out_b3;
  logic [2:0]                out_shift0, out_shift1, out_shift2, out_shift3;
  logic [1:0]                out_beat;
  logic                      out_last;
  logic [MAC_CONF_WIDTH-1:0] out_cfg;
  logic                      out_valid;
  logic                      out_ready;
  logic                      cfg_err;
  modport master (
    output cfg, opd_a, opd_b, in_valid, out_ready,
    input  in_ready, out_a0, out_a1, out_a2, out_a3, out_b0, out_b1, out_b2, out_b3,
    input  out_shift0, out_shift1, out_shift2, out_shift3, out_beat, out_last, out_cfg,
    input  out_valid, cfg_err
  );
  modport slave (
    input  cfg, opd_a, opd_b, in_valid, out_ready,
    output in_ready, out_a0, out_a1, out_a2, out_a3, out_b0, out_b1, out_b2, out_b3,
    output out_shift0, out_shift1, out_shift2, out_shift3, out_beat, out_last, out_cfg,
    output out_valid, cfg_err
  );
endinterface

// File: rtl/mac_operand_sequencer_pp_index_gen.sv
// mac_pp_index_gen: maps (mode, beat, lane) to operand byte indices and product shift
module mac_pp_index_gen
  import mac_operand_sequencer_pkg::*;
(
  input  mode_e      mode,
  input  logic [1:0] beat,
  input  logic [1:0] lane,
  output logic [1:0] a_idx,
  output logic [1:0] b_idx,
  output logic [2:0] shift
);
  // a always follows the lane; b and shift depend on how beats split the B operand
  always_comb begin
    a_idx = lane;
    b_idx = mode == MODE_QUAD ? beat : mode == MODE_DUAL ? {lane[1], beat[0]} : lane;
    shift = mode == MODE_QUAD ? {1'b0, lane} + {1'b0, beat} :
            mode == MODE_DUAL ? {2'b0, lane[0]} + {2'b0, beat[0]} : 3'd0;
  end
endmodule

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer: latches an operand pair and issues per-lane partial-product beats
module mac_operand_sequencer
  import mac_operand_sequencer_pkg::*;
#(
  parameter int MAC_MIN_WIDTH  = MAC_MIN_WIDTH_DEF,
  parameter int MAC_CONF_WIDTH = 3,
  parameter int MAC_OPD_WIDTH  = 4 * MAC_MIN_WIDTH
) (
  input logic clk,
  input logic rst,
  input logic en,
  mac_operand_sequencer_if.slave bus
);
  state_e                    state_q, state_d;
  logic [1:0]                beat_q, beat_d;
  mode_e                     mode_q, mode_d;
  logic [MAC_OPD_WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [MAC_CONF_WIDTH-1:0] cfg_q, cfg_d, out_cfg_q, out_cfg_d;
  logic [MAC_MIN_WIDTH-1:0]  out_a_q[MAC_LANES], out_a_d[MAC_LANES];
  logic [MAC_MIN_WIDTH-1:0]  out_b_q[MAC_LANES], out_b_d[MAC_LANES];
  logic [2:0]                out_shift_q[MAC_LANES], out_shift_d[MAC_LANES];
  logic [1:0]                out_beat_q, out_beat_d;
  logic                      out_last_q, out_last_d;
  logic                      out_valid_q, out_valid_d;
  logic                      cfg_err_q, cfg_err_d;
  logic [1:0]                a_idx[MAC_LANES], b_idx[MAC_LANES];
  logic [2:0]                shift[MAC_LANES];
  logic                      fire, accept, adv, load;
  assign fire = en & out_valid_q & bus.out_ready;
  assign bus.in_ready = en & (state_q == IDLE | (out_valid_q & bus.out_ready & out_last_q));
  assign accept = bus.in_ready & bus.in_valid;
  assign adv = fire & ~out_last_q;
  assign load = accept | adv;
  for (genvar l = 0; l < MAC_LANES; l++) begin : g_lane
    mac_pp_index_gen u_idx (
      .mode (mode_d),
      .beat (beat_d),
      .lane (2'(l)),
      .a_idx(a_idx[l]),
      .b_idx(b_idx[l]),
      .shift(shift[l])
    );
  end
  // next-state: a new accept restarts at beat 0, a non-final handshake advances one beat
  always_comb begin
    state_d = accept ? ISSUE : (fire & out_last_q) ? IDLE : state_q;
    beat_d = accept ? 2'd0 : adv ? beat_q + 2'd1 : beat_q;
    mode_d = accept ? seq_mode(bus.cfg[1:0]) : mode_q;
    a_d = accept ? bus.opd_a : a_q;
    b_d = accept ? bus.opd_b : b_q;
    cfg_d = accept ? bus.cfg : cfg_q;
    out_valid_d = load | (out_valid_q & ~fire);
    out_beat_d = load ? beat_d : out_beat_q;
    out_last_d = load ? beat_d == last_beat(mode_d) : out_last_q;
    out_cfg_d = load ? cfg_d : out_cfg_q;
    cfg_err_d = accept & (bus.cfg[1:0] == MODE_RSVD);
    for (int l = 0; l < MAC_LANES; l++) begin
      out_a_d[l] = load ? a_d[a_idx[l]*MAC_MIN_WIDTH +: MAC_MIN_WIDTH] : out_a_q[l];
      out_b_d[l] = load ? b_d[b_idx[l]*MAC_MIN_WIDTH +: MAC_MIN_WIDTH] : out_b_q[l];
      out_shift_d[l] = load ? shift[l] : out_shift_q[l];
    end
  end
  // state and registered outputs; reset discards any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q <= 2'd0;
      mode_q <= MODE_SINGLE;
      a_q <= '0;
      b_q <= '0;
      cfg_q <= '0;
      out_cfg_q <= '0;
      out_a_q <= '{default: '0};
      out_b_q <= '{default: '0};
      out_shift_q <= '{default: '0};
      out_beat_q <= 2'd0;
      out_last_q <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q <= beat_d;
      mode_q <= mode_d;
      a_q <= a_d;
      b_q <= b_d;
      cfg_q <= cfg_d;
      out_cfg_q <= out_cfg_d;
      out_a_q <= out_a_d;
      out_b_q <= out_b_d;
      out_shift_q <= out_shift_d;
      out_beat_q <= out_beat_d;
      out_last_q <= out_last_d;
      out_valid_q <= out_valid_d;
      cfg_err_q <= cfg_err_d;
    end
  end
  assign bus.out_a0 = out_a_q[0];
  assign bus.out_a1 = out_a_q[1];
  assign bus.out_a2 = out_a_q[2];
  assign bus.out_a3 = out_a_q[3];
  assign bus.out_b0 = out_b_q[0];
  assign bus.out_b1 = out_b_q[1];
  assign bus.out_b2 = out_b_q[2];
  assign bus.out_b3 = out_b_q[3];
  assign bus.out_shift0 = out_shift_q[0];
  assign bus.out_shift1 = out_shift_q[1];
  assign bus.out_shift2 = out_shift_q[2];
  assign bus.out_shift3 = out_shift_q[3];
  assign bus.out_beat = out_beat_q;
  assign bus.out_last = out_last_q;
  assign bus.out_cfg = out_cfg_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cfg_err = cfg_err_q;
endmodule

// File: doc/mac_operand_sequencer.md
MAC_OPERAND_SEQUENCER -- requirements
Module: mac_operand_sequencer

Interface
REQ-001 SHALL have parameter MAC_MIN_WIDTH, default 8, meaning lane operand byte width.
REQ-002 SHALL have parameter MAC_CONF_WIDTH, default 3, meaning config width; cfg[1:0] = mode (00 single, 01 dual, 10 quad, 11 reserved); cfg[2] carried through unmodified.
REQ-003 SHALL have parameter MAC_OPD_WIDTH, default 4*MAC_MIN_WIDTH, meaning packed operand width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 en  in  1  global enable; low freezes all state.
REQ-007 cfg  in  MAC_CONF_WIDTH  mode for the offered operation.
REQ-008 opd_a, opd_b  in  MAC_OPD_WIDTH each  packed operands; byte k = bits [8k+7:8k].
REQ-009 in_valid  in  1 / in_ready  out  1  input handshake.
REQ-010 out_a0..out_a3, out_b0..out_b3  out  MAC_MIN_WIDTH each  per-lane multiplier operands.
REQ-011 out_shift0..out_shift3  out  3 each  byte-shift weight (i+j) of each lane's product.
REQ-012 out_beat  out  2 / out_last  out  1 / out_cfg  out  MAC_CONF_WIDTH  beat index, final-beat flag, latched cfg.
REQ-013 out_valid  out  1 / out_ready  in  1  output handshake; cfg_err  out  1  one-cycle reserved-mode pulse.

Function
REQ-014 SHALL accept an operation on a rising edge where en & in_valid & in_ready, latching opd_a, opd_b, cfg.
REQ-015 SHALL issue beats: single 1, dual 2, quad 4; out_last high only on the final beat.
REQ-016 Single: lane l SHALL present a=A byte l, b=B byte l, shift 0.
REQ-017 Dual, beat t in 0..1: lane l with g=l>>1, i=l&1 SHALL present a=A byte 2g+i, b=B byte 2g+t, shift i+t.
REQ-018 Quad, beat t in 0..3: lane l SHALL present a=A byte l, b=B byte t, shift l+t.
REQ-019 Mode 11 SHALL be sequenced as single; cfg_err SHALL pulse high for the acceptance cycle+1 only.
REQ-020 FSM states IDLE and ISSUE; IDLE->ISSUE on accept; ISSUE->IDLE on last-beat handshake with no new accept; ISSUE->ISSUE otherwise.
REQ-021 All outputs SHALL be registered; first beat valid the cycle after acceptance (latency 1).
REQ-022 A beat advances only on en & out_valid & out_ready; while out_valid & ~out_ready all out_* SHALL hold stable.
REQ-023 in_ready = en & (state==IDLE | (out_valid & out_ready & out_last)), giving zero-bubble back-to-back operations.
REQ-024 en low SHALL hold state, beat counter, and outputs; in_ready SHALL be low.
REQ-025 cfg/opd changes while not accepting SHALL have no effect on an operation in flight.

Reset
REQ-026 On rst high, immediately: state IDLE, beat counter 0, out_valid 0, cfg_err 0, all out_a/out_b/out_shift/out_beat/out_last/out_cfg 0.
REQ-027 Reset mid-operation SHALL discard the operation; no further beats issued.
REQ-028 in_ready SHALL equal en the first cycle after rst deasserts.

Structure
REQ-029 Mode encodings, MAC_MIN_WIDTH, and beat-count per mode SHALL live in shared mac_const.vh, shared with mac_combiner_block.
REQ-030 Combinational (mode, beat, lane) -> (a_idx, b_idx, shift) mapping SHALL be sub-module mac_pp_index_gen, instantiated once per lane.

Verification
REQ-031 Single: A=0x04030201, B=0x08070605, cfg=000 -> one beat, lanes a/b = 01/05,02/06,03/07,04/08, shifts 0, out_last=1.
REQ-032 Quad: A=0x44332211, B=0x88776655, cfg=010 -> 4 beats; beat 2 lanes b=0x77, a=11,22,33,44, shifts 2,3,4,5; last on beat 3.
REQ-033 Dual: A=0xDDCCBBAA, B=0x44332211, cfg=001 -> beat 1 lanes (a,b,shift) = (AA,22,1),(BB,22,2),(CC,44,1),(DD,44,2).
REQ-034 Backpressure: quad op, out_ready low 3 cycles at beat 1 -> outputs frozen, beat 1 held, then beats 2,3; back-to-back second op first beat the cycle after last handshake.
REQ-035 Reset/err: rst asserted at quad beat 2 -> out_valid 0 same cycle; cfg=011 op -> cfg_err one-cycle pulse, single-mode beat.
